// File: rtl/rs_issue_scheduler_pkg.sv
// rs_issue_scheduler_pkg
//   Shared definitions for the reservation-station issue path: entry count,
//   functional-unit class enum and the fixed entry-to-FU map. The RS itself
//   imports the same map, so both sides agree on which entry feeds which unit.
package rs_issue_scheduler_pkg;

   localparam int NUM_ENTRIES = 5;
   localparam int PTR_W       = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LOAD  = 2'd1,
      FU_STORE = 2'd2,
      FU_MULT  = 2'd3
   } fu_type_e;

   localparam fu_type_e ENTRY_FU [NUM_ENTRIES] =
      '{FU_ALU, FU_LOAD, FU_STORE, FU_MULT, FU_MULT};

   // Loads and stores share the single memory port.
   function automatic logic is_mem_fu(input fu_type_e fu);
      return (fu == FU_LOAD) || (fu == FU_STORE);
   endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// rs_issue_scheduler_if
//   Bundle between the reservation station (master) and the issue
//   scheduler (slave).
//   master -> slave : entry_valid, entry_ready, mem_done, issue_hold, flush
//   slave -> master : issue_enable, issue_grant, issue_fu, free,
//                     mult_busy, mem_busy
interface rs_issue_scheduler_if;
   import rs_issue_scheduler_pkg::*;

   logic [NUM_ENTRIES-1:0] entry_valid;
   logic [NUM_ENTRIES-1:0] entry_ready;
   logic                   mem_done;
   logic                   issue_hold;
   logic                   flush;
   logic                   issue_enable;
   logic [NUM_ENTRIES-1:0] issue_grant;
   fu_type_e               issue_fu;
   logic [NUM_ENTRIES-1:0] free;
   logic                   mult_busy;
   logic                   mem_busy;

   modport master (
      output entry_valid, entry_ready, mem_done, issue_hold, flush,
      input  issue_enable, issue_grant, issue_fu, free, mult_busy, mem_busy
   );

   modport slave (
      input  entry_valid, entry_ready, mem_done, issue_hold, flush,
      output issue_enable, issue_grant, issue_fu, free, mult_busy, mem_busy
   );

endinterface

// File: rtl/rs_issue_scheduler_rr_arbiter.sv
// rs_issue_scheduler_rr_arbiter
//   Combinational round-robin pick: first set request bit scanning from
//   ptr_i upward, wrapping modulo N.
//   req_i       : request vector
//   ptr_i       : index with highest priority this cycle (must be < N)
//   grant_o     : one-hot grant (zero when no request)
//   grant_idx_o : binary index of the granted request
//   grant_vld_o : any request granted
module rs_issue_scheduler_rr_arbiter #(
   parameter int N     = 5,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [PTR_W-1:0] grant_idx_o,
   output logic             grant_vld_o
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr_i) + k) % N);
         if (!grant_vld_o && req_i[idx]) begin
            grant_vld_o = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
//   Picks at most one ready RS entry per cycle whose functional unit is free,
//   round-robin over entry indices, and issues it. Tracks the non-pipelined
//   multiplier and the shared load/store port, and pulses free back to the RS.
//   clock, reset : clock and asynchronous active-low reset
//   bus (slave)  : entry status / stall inputs, registered issue outputs
module rs_issue_scheduler
   import rs_issue_scheduler_pkg::*;
#(
   parameter int MULT_LATENCY = 4
) (
   input  logic                clock,
   input  logic                reset,
   rs_issue_scheduler_if.slave bus
);

   localparam int CNT_W = $clog2(MULT_LATENCY + 1);

   logic [CNT_W-1:0]       mult_cnt_q, mult_cnt_d;
   logic                   mem_busy_q, mem_busy_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_ENTRIES-1:0] last_grant_q, last_grant_d;
   logic                   issue_en_q, issue_en_d;
   logic [NUM_ENTRIES-1:0] grant_q, grant_d;
   fu_type_e               fu_q, fu_d;

   logic                   mult_free, mem_free, do_issue;
   logic [NUM_ENTRIES-1:0] fu_free, eligible, arb_grant;
   logic [PTR_W-1:0]       arb_idx;
   logic                   arb_vld;
   fu_type_e               grant_fu;

   // A counter of 1 is the multiplier's final busy cycle, so a follow-on
   // multiply may issue then and start exactly when the unit frees up.
   assign mult_free = (mult_cnt_q <= CNT_W'(1));
   // mem_done frees the port in the same cycle it is reported.
   assign mem_free  = !mem_busy_q || bus.mem_done;

   always_comb begin
      fu_free = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         case (ENTRY_FU[i])
            FU_ALU:            fu_free[i] = 1'b1;
            FU_LOAD, FU_STORE: fu_free[i] = mem_free;
            default:           fu_free[i] = mult_free;
         endcase
      end
   end

   // The entry issued last cycle is still shown valid by the RS until its
   // free pulse lands, so it is masked here to avoid a double issue.
   assign eligible = bus.entry_valid & bus.entry_ready & ~last_grant_q & fu_free;

   rs_issue_scheduler_rr_arbiter #(
      .N     (NUM_ENTRIES),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i       (eligible),
      .ptr_i       (rr_ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .grant_vld_o (arb_vld)
   );

   assign do_issue = arb_vld && !bus.issue_hold && !bus.flush;
   assign grant_fu = ENTRY_FU[arb_idx];

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      last_grant_d = '0;
      issue_en_d   = do_issue;
      grant_d      = do_issue ? arb_grant : '0;
      fu_d         = do_issue ? grant_fu : FU_ALU;
      if (do_issue) begin
         rr_ptr_d     = (arb_idx == PTR_W'(NUM_ENTRIES - 1)) ? '0 : arb_idx + 1'b1;
         last_grant_d = arb_grant;
      end

      mult_cnt_d = (mult_cnt_q != '0) ? mult_cnt_q - 1'b1 : '0;
      if (do_issue && (grant_fu == FU_MULT)) begin
         mult_cnt_d = CNT_W'(MULT_LATENCY);
      end

      // Flush drops the memory op but lets an in-flight multiply finish.
      // A new memory grant outranks a same-cycle mem_done.
      mem_busy_d = mem_busy_q;
      if (bus.flush) begin
         mem_busy_d = 1'b0;
      end else if (do_issue && is_mem_fu(grant_fu)) begin
         mem_busy_d = 1'b1;
      end else if (bus.mem_done) begin
         mem_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mult_cnt_q   <= '0;
         mem_busy_q   <= 1'b0;
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
         issue_en_q   <= 1'b0;
         grant_q      <= '0;
         fu_q         <= FU_ALU;
      end else begin
         mult_cnt_q   <= mult_cnt_d;
         mem_busy_q   <= mem_busy_d;
         rr_ptr_q     <= rr_ptr_d;
         last_grant_q <= last_grant_d;
         issue_en_q   <= issue_en_d;
         grant_q      <= grant_d;
         fu_q         <= fu_d;
      end
   end

   assign bus.issue_enable = issue_en_q;
   assign bus.issue_grant  = grant_q;
   assign bus.free         = grant_q;
   assign bus.issue_fu     = fu_q;
   assign bus.mult_busy    = (mult_cnt_q != '0);
   assign bus.mem_busy     = mem_busy_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler
//   Scoreboard bench for rs_issue_scheduler. The driver applies one cycle of
//   inputs, runs a cycle-stamped reference model and queues the outputs the
//   scheduler must show in the following cycle; a monitor on the falling edge
//   pops and compares.
module tb_rs_issue_scheduler;
   import rs_issue_scheduler_pkg::*;

   localparam int N   = 5;
   localparam int LAT = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   rs_issue_scheduler_if bus();

   rs_issue_scheduler #(.MULT_LATENCY(LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit       en;
      bit [4:0] grant;
      int       fu;
      bit       mb;
      bit       memb;
      int       cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_on = 1'b0;

   // Reference model state: cycle number, round-robin start, entry issued last
   // cycle (-1 none), cycle of the most recent multiply issue, memory port busy.
   int FU_MAP [N] = '{0, 1, 2, 3, 3};
   int cyc, rr, last, m_last;
   bit m_mem;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, c, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (mon_on) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_underflow actual=empty expected=entry");
         end else begin
            mon_e = q.pop_front();
            chk("issue_enable", 32'(bus.issue_enable), 32'(mon_e.en), mon_e.cyc);
            chk("issue_grant", 32'(bus.issue_grant), 32'(mon_e.grant), mon_e.cyc);
            chk("free", 32'(bus.free), 32'(mon_e.grant), mon_e.cyc);
            chk("issue_fu", 32'(int'(bus.issue_fu)), 32'(mon_e.fu), mon_e.cyc);
            chk("mult_busy", 32'(bus.mult_busy), 32'(mon_e.mb), mon_e.cyc);
            chk("mem_busy", 32'(bus.mem_busy), 32'(mon_e.memb), mon_e.cyc);
         end
      end
   end

   function automatic bit fu_ok(input int idx, input bit md);
      case (FU_MAP[idx])
         0:       return 1'b1;
         1, 2:    return !m_mem || md;
         default: return cyc >= m_last + LAT;
      endcase
   endfunction

   task automatic start_phase();
      exp_t e;
      cyc = 0; rr = 0; last = -1; m_last = -1000; m_mem = 1'b0;
      q.delete();
      e.en = 0; e.grant = '0; e.fu = 0; e.mb = 0; e.memb = 0; e.cyc = 0;
      q.push_back(e);
      mon_on = 1'b1;
   endtask

   task automatic drive_cycle(input bit [4:0] v, input bit [4:0] r, input bit md,
                              input bit hold, input bit fl);
      exp_t e;
      int g, idx;
      bus.entry_valid = v;
      bus.entry_ready = r;
      bus.mem_done    = md;
      bus.issue_hold  = hold;
      bus.flush       = fl;
      g = -1;
      if (!hold && !fl) begin
         for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (g < 0 && v[idx] && r[idx] && idx != last && fu_ok(idx, md)) g = idx;
         end
      end
      if (fl)                                   m_mem = 1'b0;
      else if (g >= 0 && FU_MAP[g] inside {1, 2}) m_mem = 1'b1;
      else if (md)                              m_mem = 1'b0;
      if (g >= 0) begin
         rr = (g + 1) % N;
         last = g;
         if (FU_MAP[g] == 3) m_last = cyc;
      end else begin
         last = -1;
      end
      e.en    = (g >= 0);
      e.grant = (g >= 0) ? 5'(1 << g) : 5'd0;
      e.fu    = (g >= 0) ? FU_MAP[g] : 0;
      cyc++;
      e.mb    = (cyc > m_last) && (cyc <= m_last + LAT);
      e.memb  = m_mem;
      e.cyc   = cyc;
      q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic end_phase();
      @(negedge clock);
      #1;
      mon_on = 1'b0;
      chk("queue_drain", 32'(q.size()), 32'd0, cyc);
      q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_enable"}, 32'(bus.issue_enable), 32'd0, -1);
      chk({tag, "_grant"}, 32'(bus.issue_grant), 32'd0, -1);
      chk({tag, "_free"}, 32'(bus.free), 32'd0, -1);
      chk({tag, "_fu"}, 32'(int'(bus.issue_fu)), 32'd0, -1);
      chk({tag, "_mult_busy"}, 32'(bus.mult_busy), 32'd0, -1);
      chk({tag, "_mem_busy"}, 32'(bus.mem_busy), 32'd0, -1);
   endtask

   task automatic idle_inputs();
      bus.entry_valid = '0;
      bus.entry_ready = '0;
      bus.mem_done    = 1'b0;
      bus.issue_hold  = 1'b0;
      bus.flush       = 1'b0;
   endtask

   // Asserts reset mid-cycle, checks the outputs clear without a clock edge,
   // then releases reset just after an edge and restarts the model.
   task automatic async_reset_restart(input string tag);
      mon_on = 1'b0;
      q.delete();
      reset = 1'b0;
      #1;
      check_zero(tag);
      idle_inputs();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      start_phase();
   endtask

   task automatic random_cycles(input int n);
      bit [4:0] v, r;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < N; b++) begin
            v[b] = ($urandom_range(0, 3) != 0);
            r[b] = ($urandom_range(0, 3) != 0);
         end
         drive_cycle(v, r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 15) == 0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      idle_inputs();
      repeat (3) @(posedge clock);
      #1;
      check_zero("reset");
      reset = 1'b1;
      start_phase();

      // single ALU entry, masked the cycle after its grant
      repeat (3) drive_cycle(5'b00001, 5'b00001, 0, 0, 0);
      drive_cycle(5'b00000, 5'b00000, 0, 0, 0);
      // both multiplier entries ready together
      repeat (12) drive_cycle(5'b11000, 5'b11000, 0, 0, 0);
      repeat (4) drive_cycle(5'b00000, 5'b00000, 0, 0, 0);
      // load, then store blocked until mem_done, granted on mem_done
      drive_cycle(5'b00010, 5'b00010, 0, 0, 0);
      repeat (3) drive_cycle(5'b00100, 5'b00100, 0, 0, 0);
      drive_cycle(5'b00100, 5'b00100, 1, 0, 0);
      drive_cycle(5'b00000, 5'b00000, 0, 0, 0);
      drive_cycle(5'b00000, 5'b00000, 1, 0, 0);
      drive_cycle(5'b00000, 5'b00000, 1, 0, 0);
      // issue_hold
      repeat (3) drive_cycle(5'b00001, 5'b00001, 0, 1, 0);
      drive_cycle(5'b00001, 5'b00001, 0, 0, 0);
      drive_cycle(5'b00000, 5'b00000, 0, 0, 0);
      // multiply and load in flight, then flush with everything ready
      drive_cycle(5'b01000, 5'b01000, 0, 0, 0);
      drive_cycle(5'b00010, 5'b00010, 0, 0, 0);
      drive_cycle(5'b11111, 5'b11111, 0, 0, 1);
      repeat (6) drive_cycle(5'b00000, 5'b00000, 0, 0, 0);
      // everything ready: rotation
      repeat (20) drive_cycle(5'b11111, 5'b11111, ($urandom_range(0, 1) == 1), 0, 0);
      random_cycles(300);
      end_phase();

      // reset while a multiply is in flight and an issue pulse is showing
      async_reset_restart("reset_idle");
      drive_cycle(5'b01000, 5'b01000, 0, 0, 0);
      mon_on = 1'b0;
      chk("pre_reset_enable", 32'(bus.issue_enable), 32'd1, cyc);
      chk("pre_reset_mult_busy", 32'(bus.mult_busy), 32'd1, cyc);
      #2;
      async_reset_restart("reset_mid_mult");
      random_cycles(200);
      end_phase();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Issue controller for the 5-entry reservation station. Each cycle it picks at most one ready RS entry whose functional unit is free and issues it. The pick is round-robin over entry indices. It tracks occupancy of the non-pipelined multiplier and the shared load/store memory port, and pulses the per-entry free vector back to the RS so issued entries are released.

Parameters:
NUM_ENTRIES, 5, RS entry count (entry-to-FU map fixed in package)
MULT_LATENCY, 4, cycles the multiplier stays busy after an issue (>=1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
entry_valid  input  NUM_ENTRIES  RS entry busy/allocated flags
entry_ready  input  NUM_ENTRIES  both source tags ready, per entry
mem_done  input  1  memory unit finished current load/store
issue_hold  input  1  suppress new issue this cycle (CDB/structural stall)
flush  input  1  squash: cancel issue decision this cycle, clear memory-busy
issue_enable  output  1  registered: an issue occurred last cycle
issue_grant  output  NUM_ENTRIES  registered one-hot index of issued entry
issue_fu  output  FU_TYPE  registered FU class of issued entry
free  output  NUM_ENTRIES  registered one-cycle release pulse to RS (== issue_grant)
mult_busy  output  1  multiplier occupied
mem_busy  output  1  memory port occupied

Behaviour:
- Reset (reset low, async): issue_enable=0, issue_grant=0, free=0, issue_fu=FU_ALU, mult counter=0, mult_busy=0, mem_busy=0, rr_ptr=0, last_grant mask=0.
- Entry FU map: 0=ALU, 1=LOAD, 2=STORE, 3=MULT, 4=MULT.
- Eligibility (combinational, cycle t): eligible[i] = entry_valid[i] & entry_ready[i] & ~last_grant[i] & fu_free(i).
  - fu_free: ALU always free.
  - LOAD/STORE free iff ~mem_busy | mem_done; both share one port.
  - MULT free iff mult counter==0, or counter==1 (last busy cycle).
- last_grant masks the entry issued at t-1. The RS still shows it valid for one cycle, until free takes effect.
- Selection: first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_ENTRIES. At most one grant per cycle. No grant if issue_hold or flush.
- Latency: decision at cycle t, outputs registered at edge ending t. Consequences:
  - issue_enable, issue_grant, free and issue_fu are valid during t+1 only, as a single-cycle pulse.
  - When there is no grant, all of these outputs are 0 in t+1.
- On grant of index g: rr_ptr <= (g+1) mod NUM_ENTRIES; last_grant <= onehot(g). Without a grant, rr_ptr holds and last_grant <= 0.
- Multiplier issue: counter <= MULT_LATENCY. The counter decrements each cycle while nonzero. mult_busy = (counter != 0). A back-to-back MULT may issue in the cycle where counter==1.
- Memory issue: mem_busy <= 1. mem_done clears mem_busy.
  - mem_done and a new LOAD/STORE grant in the same cycle: mem_busy stays 1.
  - mem_done while not busy: ignored.
- flush: blocks the grant in that cycle and clears mem_busy at the edge. It does not clear the mult counter, because the in-flight multiply still completes. Outputs already registered are not retracted.
- Simultaneous ready MULT entries 3 and 4: the round-robin order decides, and only one issues. The other waits until mult_busy releases.
- Reset asserted mid-operation: all state clears immediately, with no pending free pulse. The RS is reset in the same domain.

Decomposition:
- Shared package: FU_TYPE enum (FU_ALU, FU_LOAD, FU_STORE, FU_MULT) and the ENTRY_FU[NUM_ENTRIES] constant map. The RS uses the same map.
- One natural sub-module: rr_arbiter (parameterised N-bit request/pointer to one-hot grant, combinational). The scheduler wraps it with FU-occupancy and registered outputs.

Test Plan:
- Reset release, entry_valid=entry_ready=5'b00001 -> at t+1: issue_enable=1, issue_grant=5'b00001, free=5'b00001, issue_fu=FU_ALU. At t+2: issue_enable=0 because of the last_grant mask, even though entry_valid is still 1.
- Entries 3 and 4 ready together, rr_ptr=0, MULT_LATENCY=4 -> grant 5'b01000. mult_busy is high for 4 cycles. Entry 4 issues on the 4th cycle after the first issue. No overlap.
- LOAD issued, then STORE ready -> STORE blocked while mem_busy=1. Assert mem_done -> STORE granted in the same cycle, and mem_busy stays 1.
- All five entries ready repeatedly, each reloaded two cycles after free -> grants rotate in order. No entry starves beyond NUM_ENTRIES grants, subject to FU busy.
- issue_hold=1 with entry 0 ready -> no issue_enable. Drop hold -> grant next edge.
- MULT in flight with counter=3 and LOAD busy, then pulse flush -> mem_busy=0 next cycle, mult_busy still counts down to 0, and no grant is issued in the flush cycle.
- Reset pulsed low mid-multiply -> mult_busy=0 and all outputs 0 immediately (async).
